log_ram_ctrl: RTL and testbench
===============================

Name: log_ram_ctrl

Overview:
- Capture-buffer stage directly downstream of the register file's logging controls.
- Consumes o_en_write, o_data_sel_for_log, o_en_read_from_ram and o_read_adrs from the register file.
- Records one selected 32-bit receiver signal per valid strobe into a single-shot RAM of RAM_DEPTH words.
- Returns stored words to the register file's i_data_ram_for_read input for micro read-back over GPIO.

Parameters:
- NB_DATA, 32, width of each logged word and of the read data.
- RAM_DEPTH, 32768, number of RAM words; power of two.
- N_SRC, 8, number of selectable sources; selector is 3 bits wide.

Ports:
- clk  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_en_write  input  1  logging enable level; a rising edge arms a capture.
- i_data_sel  input  3  source index, latched at capture start.
- i_src_data  input  N_SRC*NB_DATA  flattened sources; source k occupies bits [k*NB_DATA +: NB_DATA].
- i_src_valid  input  1  one-cycle strobe marking a new sample on all sources.
- i_en_read  input  1  read enable.
- i_read_adrs  input  $clog2(RAM_DEPTH)  read address.
- o_read_data  output  NB_DATA  registered read data.
- o_log_busy  output  1  high while in LOG.
- o_log_full  output  1  high while in FULL.
- o_wr_count  output  $clog2(RAM_DEPTH)+1  number of words written by the current or last capture.

Behaviour:
- Reset (i_reset=1 on a clk edge):
  - state=IDLE, wr_addr=0, o_wr_count=0, o_log_busy=0, o_log_full=0, o_read_data=0.
  - sel_latched=0; en_write_d (edge-detector register)=0.
  - RAM contents are NOT cleared.
  - Reset has priority over all other events, including a capture in progress.
- Edge detect: start = i_en_write & ~en_write_d; en_write_d <= i_en_write every non-reset cycle.
  - If i_en_write is high on the first cycle after reset, that cycle counts as a start.
- States: IDLE, LOG, FULL.
  - IDLE --start--> LOG.
  - FULL --start--> LOG.
  - On entering LOG: wr_addr<=0, o_wr_count<=0, sel_latched<=i_data_sel.
  - LOG: each cycle with i_src_valid=1, write source[sel_latched] to RAM[wr_addr], then wr_addr++ and o_wr_count++.
  - LOG, write to address RAM_DEPTH-1 -> FULL; o_wr_count=RAM_DEPTH; wr_addr wraps to 0 but no further writes occur.
  - LOG, i_en_write=0 -> IDLE (abort). No write in that cycle even if i_src_valid=1. Partial data and o_wr_count are retained.
  - FULL holds until the next start. Deasserting i_en_write in FULL does not change state.
  - The start cycle itself never writes; the first write is on the first valid strobe after entry.
- Ignored inputs:
  - i_data_sel changes during LOG are ignored.
  - A start while already in LOG is impossible by construction (no rising edge while the level stays high).
- Flags are registered and mirror state: o_log_busy = (state==LOG), o_log_full = (state==FULL).
- Read path:
  - Simple dual-port RAM, independent of write state.
  - When i_en_read=1, o_read_data <= RAM[i_read_adrs]; latency is 1 clk.
  - When i_en_read=0, o_read_data holds its value.
  - Same-address read and write in one cycle: read-first, returning the old word.
- Width rules:
  - No arithmetic on data; words are stored bit-exact, signed values unchanged.
  - o_wr_count is one bit wider than the address so RAM_DEPTH is representable.

Test Plan:
- Full capture: reset; i_data_sel=2, src2 = incrementing counter starting 0x100, i_src_valid every cycle; raise i_en_write -> o_log_busy=1 next cycle; after 32768 strobes o_log_full=1, o_wr_count=32768; reading addresses 0, 1, 32767 returns 0x100, 0x101, 0x80FF, each one clk after the address.
- Abort: start capture, i_src_valid every 4th cycle, drop i_en_write after 10 writes -> state IDLE, o_wr_count=10, addresses 0..9 hold data, address 10 keeps its prior content, no write on the abort cycle.
- Source latch: start with sel=5, change sel to 1 mid-capture -> all stored words equal src5 samples.
- Re-arm from FULL: after FULL, toggle i_en_write 1->0->1 -> LOG, o_wr_count=0, new data overwrites from address 0; holding i_en_write high in FULL without a toggle causes no restart.
- Reset mid-capture: assert i_reset after 100 writes -> o_log_busy=0, o_wr_count=0, o_read_data=0; RAM[0..99] still readable with the old data; i_en_write held high after reset release starts a new capture.
- Read/write collision: read address 7 in the same cycle it is written with 0xDEADBEEF -> o_read_data shows the old word; a read one cycle later returns 0xDEADBEEF.

Source files
------------

// File: rtl/log_ram_ctrl.sv
// rtl/log_ram_ctrl.sv - single-shot capture RAM for register-file logging with 1-cycle read-back
// One selected source word is stored per valid strobe; the buffer stops when it fills or logging drops.
module log_ram_ctrl #(
  parameter int NB_DATA   = 32,
  parameter int RAM_DEPTH = 32768,
  parameter int N_SRC     = 8
) (
  input  logic                           clk,
  input  logic                           i_reset,
  input  logic                           i_en_write,
  input  logic [$clog2(N_SRC)-1:0]       i_data_sel,
  input  logic [N_SRC*NB_DATA-1:0]       i_src_data,
  input  logic                           i_src_valid,
  input  logic                           i_en_read,
  input  logic [$clog2(RAM_DEPTH)-1:0]   i_read_adrs,
  output logic [NB_DATA-1:0]             o_read_data,
  output logic                           o_log_busy,
  output logic                           o_log_full,
  output logic [$clog2(RAM_DEPTH):0]     o_wr_count
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int SW = $clog2(N_SRC);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOG,
    ST_FULL
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [AW:0]         wr_count_q, wr_count_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                en_write_prev_q, en_write_prev_d;
  logic                log_busy_q, log_busy_d;
  logic                log_full_q, log_full_d;
  logic [NB_DATA-1:0]  read_data_q;

  logic                start;
  logic                wr_en;
  logic [NB_DATA-1:0]  src_word;
  logic [NB_DATA-1:0]  src_arr [N_SRC];
  logic [NB_DATA-1:0]  mem [RAM_DEPTH];

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    assign src_arr[k] = i_src_data[k*NB_DATA +: NB_DATA];
  end

  assign src_word = src_arr[sel_q];
  assign start    = i_en_write & ~en_write_prev_q;

  always_comb begin
    state_d         = state_q;
    wr_addr_d       = wr_addr_q;
    wr_count_d      = wr_count_q;
    sel_d           = sel_q;
    wr_en           = 1'b0;
    en_write_prev_d = i_en_write;

    case (state_q)
      ST_IDLE, ST_FULL: begin
        if (start) begin
          state_d    = ST_LOG;
          wr_addr_d  = '0;
          wr_count_d = '0;
          sel_d      = i_data_sel;
        end
      end
      ST_LOG: begin
        // Dropping the enable wins over a coincident strobe: that sample is discarded.
        if (!i_en_write) begin
          state_d = ST_IDLE;
        end else if (i_src_valid) begin
          wr_en      = 1'b1;
          wr_addr_d  = wr_addr_q + AW'(1);
          wr_count_d = wr_count_q + (AW+1)'(1);
          if (wr_addr_q == LAST_ADDR) begin
            state_d = ST_FULL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    log_busy_d = (state_d == ST_LOG);
    log_full_d = (state_d == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q         <= ST_IDLE;
      wr_addr_q       <= '0;
      wr_count_q      <= '0;
      sel_q           <= '0;
      en_write_prev_q <= 1'b0;
      log_busy_q      <= 1'b0;
      log_full_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_addr_q       <= wr_addr_d;
      wr_count_q      <= wr_count_d;
      sel_q           <= sel_d;
      en_write_prev_q <= en_write_prev_d;
      log_busy_q      <= log_busy_d;
      log_full_q      <= log_full_d;
    end
  end

  // Storage is deliberately not reset so a capture survives a controller reset.
  always_ff @(posedge clk) begin
    if (!i_reset && wr_en) begin
      mem[wr_addr_q] <= src_word;
    end
  end

  // Read-first port: a same-cycle write to this address is seen on the next read.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      read_data_q <= '0;
    end else if (i_en_read) begin
      read_data_q <= mem[i_read_adrs];
    end
  end

  assign o_read_data = read_data_q;
  assign o_log_busy  = log_busy_q;
  assign o_log_full  = log_full_q;
  assign o_wr_count  = wr_count_q;

endmodule

// File: tb/tb_log_ram_ctrl.sv
// tb/tb_log_ram_ctrl.sv - self-checking bench for log_ram_ctrl
// Behavioural model of the capture buffer plus literal checks of the directed scenarios.
module tb_log_ram_ctrl;

  localparam int NB    = 32;
  localparam int DEPTH = 32768;
  localparam int NSRC  = 8;
  localparam int AW    = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en_write;
  logic [2:0]           data_sel;
  logic [NSRC*NB-1:0]   src_data;
  logic                 src_valid;
  logic                 en_read;
  logic [AW-1:0]        read_adrs;
  logic [NB-1:0]        o_read_data;
  logic                 o_log_busy;
  logic                 o_log_full;
  logic [AW:0]          o_wr_count;

  log_ram_ctrl #(.NB_DATA(NB), .RAM_DEPTH(DEPTH), .N_SRC(NSRC)) dut (
    .clk         (clk),
    .i_reset     (rst),
    .i_en_write  (en_write),
    .i_data_sel  (data_sel),
    .i_src_data  (src_data),
    .i_src_valid (src_valid),
    .i_en_read   (en_read),
    .i_read_adrs (read_adrs),
    .o_read_data (o_read_data),
    .o_log_busy  (o_log_busy),
    .o_log_full  (o_log_full),
    .o_wr_count  (o_wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a capture is "count words written so far"; next write address is simply count.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          m_st  = 0;  // 0 idle, 1 logging, 2 full
  int          m_cnt = 0;
  int          m_sel = 0;
  bit          m_prev = 1'b0;
  logic [31:0] m_rd = '0;
  bit          m_rd_known = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_cnt = 0; m_sel = 0; m_prev = 1'b0;
      m_rd = '0; m_rd_known = 1'b1;
    end else begin
      if (en_read) begin
        m_rd       = m_mem[read_adrs];
        m_rd_known = m_known[read_adrs];
      end
      if (m_st == 1) begin
        if (!en_write) begin
          m_st = 0;
        end else if (src_valid) begin
          m_mem[m_cnt]   = src_data[m_sel*NB +: NB];
          m_known[m_cnt] = 1'b1;
          m_cnt++;
          if (m_cnt == DEPTH) m_st = 2;
        end
      end else if (en_write && !m_prev) begin
        m_st = 1; m_cnt = 0; m_sel = int'(data_sel);
      end
      m_prev = en_write;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'd0, o_log_busy}, {63'd0, m_st == 1});
      check("full", {63'd0, o_log_full}, {63'd0, m_st == 2});
      check("wr_count", 64'(o_wr_count), 64'(m_cnt));
      if (m_rd_known) check("read_data", 64'(o_read_data), 64'(m_rd));
    end
  end

  task automatic set_src(input int k, input logic [31:0] v);
    src_data[k*NB +: NB] = v;
  endtask

  task automatic rand_srcs();
    for (int k = 0; k < NSRC; k++) set_src(k, $urandom);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [31:0] rec  [10];
  logic [31:0] rec2 [100];

  initial begin
    rst = 1'b1; en_write = 1'b0; data_sel = '0; src_data = '0;
    src_valid = 1'b0; en_read = 1'b0; read_adrs = '0;
    cyc(); cyc();
    check("rst_busy", {63'd0, o_log_busy}, 64'd0);
    check("rst_full", {63'd0, o_log_full}, 64'd0);
    check("rst_count", 64'(o_wr_count), 64'd0);
    check("rst_rd", 64'(o_read_data), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Full capture: src2 counts from 0x100, strobe every cycle.
    en_write = 1'b1; data_sel = 3'd2; rand_srcs(); cyc();
    check("start_busy", {63'd0, o_log_busy}, 64'd1);
    for (int k = 0; k < DEPTH; k++) begin
      src_valid = 1'b1; rand_srcs(); set_src(2, 32'h100 + k); cyc();
    end
    src_valid = 1'b0;
    check("full_flag", {63'd0, o_log_full}, 64'd1);
    check("full_count", 64'(o_wr_count), 64'd32768);
    en_read = 1'b1; read_adrs = 15'd0; cyc();
    check("rd_addr0", 64'(o_read_data), 64'h100);
    read_adrs = 15'd1; cyc();
    check("rd_addr1", 64'(o_read_data), 64'h101);
    read_adrs = 15'd32767; cyc();
    check("rd_addr_last", 64'(o_read_data), 64'h80FF);
    en_read = 1'b0;

    // Held enable in FULL must not restart; a toggle re-arms.
    src_valid = 1'b1; rand_srcs(); cyc(); cyc(); cyc();
    check("hold_full", {63'd0, o_log_full}, 64'd1);
    check("hold_count", 64'(o_wr_count), 64'd32768);
    src_valid = 1'b0; en_write = 1'b0; cyc();
    check("drop_in_full", {63'd0, o_log_full}, 64'd1);
    en_write = 1'b1; data_sel = 3'd3; cyc();
    check("rearm_busy", {63'd1, o_log_busy} & 64'd1, 64'd1);
    check("rearm_count", 64'(o_wr_count), 64'd0);
    for (int k = 0; k < 5; k++) begin
      src_valid = 1'b1; rand_srcs(); cyc();
    end
    src_valid = 1'b0; en_write = 1'b0; cyc();
    check("rearm_words", 64'(o_wr_count), 64'd5);

    // Abort with sparse strobes; selector changes mid-capture are ignored.
    en_write = 1'b1; data_sel = 3'd5; cyc();
    begin
      int nw = 0;
      for (int c = 0; nw < 10; c++) begin
        rand_srcs();
        src_valid = (c % 4 == 3);
        if (nw >= 5) data_sel = 3'd1;
        if (src_valid) begin
          rec[nw] = src_data[5*NB +: NB];
          nw++;
        end
        cyc();
      end
    end
    src_valid = 1'b0; cyc(); cyc(); cyc();
    src_valid = 1'b1; en_write = 1'b0; rand_srcs(); cyc();
    src_valid = 1'b0;
    check("abort_busy", {63'd0, o_log_busy}, 64'd0);
    check("abort_count", 64'(o_wr_count), 64'd10);
    en_read = 1'b1; read_adrs = 15'd10; cyc();
    check("abort_addr10_old", 64'(o_read_data), 64'h10A);
    read_adrs = 15'd0; cyc();
    check("latch_addr0", 64'(o_read_data), 64'(rec[0]));
    read_adrs = 15'd9; cyc();
    check("latch_addr9", 64'(o_read_data), 64'(rec[9]));
    en_read = 1'b0;

    // Read/write collision on address 7.
    en_write = 1'b1; data_sel = 3'd0; cyc();
    for (int k = 0; k < 7; k++) begin
      src_valid = 1'b1; rand_srcs(); cyc();
    end
    rand_srcs(); set_src(0, 32'hDEADBEEF); en_read = 1'b1; read_adrs = 15'd7; cyc();
    check("collide_old", 64'(o_read_data), 64'(rec[7]));
    src_valid = 1'b0; cyc();
    check("collide_new", 64'(o_read_data), 64'hDEADBEEF);
    en_read = 1'b0; en_write = 1'b0; cyc();

    // Reset mid-capture, enable held through reset.
    en_write = 1'b1; data_sel = 3'd4; cyc();
    for (int k = 0; k < 100; k++) begin
      src_valid = 1'b1; rand_srcs(); rec2[k] = src_data[4*NB +: NB]; cyc();
    end
    src_valid = 1'b0; rst = 1'b1; cyc();
    check("midrst_busy", {63'd0, o_log_busy}, 64'd0);
    check("midrst_full", {63'd0, o_log_full}, 64'd0);
    check("midrst_count", 64'(o_wr_count), 64'd0);
    check("midrst_rd", 64'(o_read_data), 64'd0);
    rst = 1'b0; cyc();
    check("restart_busy", {63'd0, o_log_busy}, 64'd1);
    en_read = 1'b1;
    for (int a = 0; a < 100; a++) begin
      read_adrs = AW'(a); cyc();
      if (a == 50) check("retained_addr50", 64'(o_read_data), 64'(rec2[50]));
    end
    en_read = 1'b0; en_write = 1'b0; cyc();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) en_write = ~en_write;
      data_sel  = 3'($urandom_range(0, 7));
      src_valid = $urandom_range(0, 1);
      rand_srcs();
      en_read   = $urandom_range(0, 1);
      read_adrs = AW'($urandom_range(0, 63));
      cyc();
    end
    rst = 1'b0; en_write = 1'b0; src_valid = 1'b0; en_read = 1'b0;
    cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
